// File: rtl/instr_decode.sv
// instr_decode: MIPS ID stage - decode, register file, branch and hazard resolution.
// Optional feature macro: DECODE_WB_BYPASS_EN (write-first register file reads).

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module instr_decode #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clk_87,
    input  logic                    rst_87,
    input  logic [`INSTR_WIDTH-1:0] instr_87,
    input  logic [`ADDR_WIDTH-1:0]  npc_87,
    input  logic                    wb_en_87,
    input  logic [REG_AW-1:0]       wb_addr_87,
    input  logic [DATA_W-1:0]       wb_data_87,
    input  logic                    ex_wr_87,
    input  logic [REG_AW-1:0]       ex_rd_87,
    input  logic                    ex_ld_87,
    input  logic                    mem_wr_87,
    input  logic [REG_AW-1:0]       mem_rd_87,
    output logic [`ADDR_WIDTH-1:0]  br_pc_87,
    output logic                    br_sel_87,
    output logic                    id_valid_87,
    output logic [DATA_W-1:0]       id_rs_87,
    output logic [DATA_W-1:0]       id_rt_87,
    output logic [DATA_W-1:0]       id_imm_87,
    output logic [REG_AW-1:0]       id_dst_87,
    output logic [3:0]              id_alu_87,
    output logic [4:0]              id_ctl_87,
    output logic [`ADDR_WIDTH-1:0]  id_npc_87,
    output logic                    id_illegal_87
);
    localparam int AW   = `ADDR_WIDTH;
    localparam int NREG = 1 << REG_AW;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     expect_q, expect_d;
    logic [DATA_W-1:0] rf_q [NREG];

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [3:0]        alu_q, alu_d;
    logic [4:0]        ctl_q, ctl_d;
    logic [AW-1:0]     npc_q, npc_d;
    logic              ill_q, ill_d;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [15:0]       imm16;
    logic [25:0]       imm26;

    assign op    = instr_87[31:26];
    assign rs    = instr_87[25:21];
    assign rt    = instr_87[20:16];
    assign rd    = instr_87[15:11];
    assign funct = instr_87[5:0];
    assign imm16 = instr_87[15:0];
    assign imm26 = instr_87[25:0];

    logic       legal, rw, mr, mw, m2r, asrc;
    logic       use_rs, use_rt, is_br, is_bne, is_j, is_jr;
    logic       zext, is_lui, dst_rd;
    logic [3:0] alu;

    always_comb begin
        legal  = 1'b0;
        rw     = 1'b0;
        mr     = 1'b0;
        mw     = 1'b0;
        m2r    = 1'b0;
        asrc   = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        is_br  = 1'b0;
        is_bne = 1'b0;
        is_j   = 1'b0;
        is_jr  = 1'b0;
        zext   = 1'b0;
        is_lui = 1'b0;
        dst_rd = 1'b0;
        alu    = ALU_ADD;
        unique case (op)
            6'h00: begin
                legal  = 1'b1;
                rw     = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
                dst_rd = 1'b1;
                unique case (funct)
                    6'h20, 6'h21: alu = ALU_ADD;
                    6'h22, 6'h23: alu = ALU_SUB;
                    6'h24: alu = ALU_AND;
                    6'h25: alu = ALU_OR;
                    6'h26: alu = ALU_XOR;
                    6'h27: alu = ALU_NOR;
                    6'h2A: alu = ALU_SLT;
                    6'h00: begin
                        alu    = ALU_SLL;
                        use_rs = 1'b0;
                    end
                    6'h02: begin
                        alu    = ALU_SRL;
                        use_rs = 1'b0;
                    end
                    6'h08: begin
                        rw     = 1'b0;
                        use_rt = 1'b0;
                        is_jr  = 1'b1;
                    end
                    default: begin
                        legal  = 1'b0;
                        rw     = 1'b0;
                        use_rs = 1'b0;
                        use_rt = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                legal  = 1'b1;
                rw     = 1'b1;
                asrc   = 1'b1;
                use_rs = 1'b1;
                zext   = op[2];
                unique case (op[2:0])
                    3'd2:    alu = ALU_SLT;
                    3'd4:    alu = ALU_AND;
                    3'd5:    alu = ALU_OR;
                    3'd6:    alu = ALU_XOR;
                    default: alu = ALU_ADD;
                endcase
            end
            6'h0F: begin
                legal  = 1'b1;
                rw     = 1'b1;
                asrc   = 1'b1;
                is_lui = 1'b1;
                alu    = ALU_LUI;
            end
            6'h23: begin
                legal  = 1'b1;
                rw     = 1'b1;
                mr     = 1'b1;
                m2r    = 1'b1;
                asrc   = 1'b1;
                use_rs = 1'b1;
            end
            6'h2B: begin
                legal  = 1'b1;
                mw     = 1'b1;
                asrc   = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'h04, 6'h05: begin
                legal  = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
                is_br  = 1'b1;
                is_bne = op[0];
                alu    = ALU_SUB;
            end
            6'h02: begin
                legal = 1'b1;
                is_j  = 1'b1;
            end
            default: ;
        endcase
        // The all-zero word is sll $0,$0,0 and must never write back
        if (instr_87 == '0) rw = 1'b0;
    end

    logic [DATA_W-1:0] rs_val, rt_val;

    always_comb begin
        rs_val = rf_q[rs];
        rt_val = rf_q[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en_87 && wb_addr_87 != '0 && wb_addr_87 == rs) rs_val = wb_data_87;
        if (wb_en_87 && wb_addr_87 != '0 && wb_addr_87 == rt) rt_val = wb_data_87;
`endif
    end

    logic hit_ex, hit_mem, hit_wb;
    logic ld_hz, br_hz, wb_hz, hz;

    assign hit_ex  = ex_rd_87 != '0 &&
                     ((use_rs && rs == ex_rd_87) || (use_rt && rt == ex_rd_87));
    assign hit_mem = mem_rd_87 != '0 &&
                     ((use_rs && rs == mem_rd_87) || (use_rt && rt == mem_rd_87));
    assign hit_wb  = wb_addr_87 != '0 &&
                     ((use_rs && rs == wb_addr_87) || (use_rt && rt == wb_addr_87));

    assign ld_hz = ex_ld_87 && hit_ex;
    assign br_hz = (is_br || is_jr) &&
                   ((ex_wr_87 && hit_ex) || (mem_wr_87 && hit_mem));
`ifdef DECODE_WB_BYPASS_EN
    assign wb_hz = 1'b0;
`else
    assign wb_hz = wb_en_87 && hit_wb;
`endif
    assign hz = ld_hz || br_hz || wb_hz;

    logic          taken;
    logic [AW-1:0] target;
    logic [AW-1:0] br_off;
    logic [DATA_W-1:0] imm_ext;

    assign br_off = {{(AW-18){imm16[15]}}, imm16, 2'b00};
    assign taken  = is_j || is_jr ||
                    (is_br && (is_bne ? (rs_val != rt_val) : (rs_val == rt_val)));

    always_comb begin
        if (is_jr)     target = AW'(rs_val);
        else if (is_j) target = {npc_87[AW-1:28], imm26, 2'b00};
        else           target = npc_87 + br_off;
    end

    always_comb begin
        if (is_lui)    imm_ext = {imm16, {(DATA_W-16){1'b0}}};
        else if (zext) imm_ext = {{(DATA_W-16){1'b0}}, imm16};
        else           imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    end

    logic accept, drop, bad, stall, xfer, go, load;

    assign accept = (state_q == S_RUN) || (npc_87 == expect_q);
    assign drop   = !accept;
    assign bad    = accept && !legal;
    assign stall  = accept && legal && hz;
    assign xfer   = accept && legal && !hz && taken;
    assign go     = accept && legal && !hz && !taken;

    always_comb begin
        state_d   = state_q;
        expect_d  = expect_q;
        ill_d     = ill_q;
        br_sel_87 = 1'b0;
        br_pc_87  = '0;
        load      = 1'b0;
        unique case (1'b1)
            drop: ;
            bad: begin
                ill_d   = 1'b1;
                state_d = S_RUN;
            end
            stall: begin
                br_sel_87 = 1'b1;
                br_pc_87  = npc_87 - AW'(4);
                state_d   = S_WAIT;
                expect_d  = npc_87;
            end
            xfer: begin
                br_sel_87 = 1'b1;
                br_pc_87  = target;
                state_d   = S_WAIT;
                expect_d  = target + AW'(4);
                load      = 1'b1;
            end
            go: begin
                state_d = S_RUN;
                load    = 1'b1;
            end
            default: ;
        endcase
        if (rst_87) br_sel_87 = 1'b0;

        valid_d = load;
        rs_d    = load ? rs_val : '0;
        rt_d    = load ? rt_val : '0;
        imm_d   = load ? imm_ext : '0;
        dst_d   = load ? (dst_rd ? rd : rt) : '0;
        alu_d   = load ? alu : 4'd0;
        ctl_d   = load ? {rw, mr, mw, m2r, asrc} : 5'd0;
        npc_d   = load ? npc_87 : '0;
    end

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            state_q  <= S_RUN;
            expect_q <= '0;
            ill_q    <= 1'b0;
            valid_q  <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            dst_q    <= '0;
            alu_q    <= '0;
            ctl_q    <= '0;
            npc_q    <= '0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            ill_q    <= ill_d;
            valid_q  <= valid_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            imm_q    <= imm_d;
            dst_q    <= dst_d;
            alu_q    <= alu_d;
            ctl_q    <= ctl_d;
            npc_q    <= npc_d;
        end
    end

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_en_87 && wb_addr_87 != '0) begin
            rf_q[wb_addr_87] <= wb_data_87;
        end
    end

    assign id_valid_87   = valid_q;
    assign id_rs_87      = rs_q;
    assign id_rt_87      = rt_q;
    assign id_imm_87     = imm_q;
    assign id_dst_87     = dst_q;
    assign id_alu_87     = alu_q;
    assign id_ctl_87     = ctl_q;
    assign id_npc_87     = npc_q;
    assign id_illegal_87 = ill_q;

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed plan cases plus random traffic against a
// mnemonic-level reference model of the decode stage.

module tb_instr_decode;
    logic        clk_87 = 1'b0;
    logic        rst_87 = 1'b1;
    logic [31:0] instr_87 = '0;
    logic [31:0] npc_87 = '0;
    logic        wb_en_87 = 1'b0;
    logic [4:0]  wb_addr_87 = '0;
    logic [31:0] wb_data_87 = '0;
    logic        ex_wr_87 = 1'b0;
    logic [4:0]  ex_rd_87 = '0;
    logic        ex_ld_87 = 1'b0;
    logic        mem_wr_87 = 1'b0;
    logic [4:0]  mem_rd_87 = '0;
    logic [31:0] br_pc_87;
    logic        br_sel_87;
    logic        id_valid_87;
    logic [31:0] id_rs_87, id_rt_87, id_imm_87;
    logic [4:0]  id_dst_87;
    logic [3:0]  id_alu_87;
    logic [4:0]  id_ctl_87;
    logic [31:0] id_npc_87;
    logic        id_illegal_87;

    always #5 clk_87 = ~clk_87;

    instr_decode dut (
        .clk_87(clk_87), .rst_87(rst_87), .instr_87(instr_87), .npc_87(npc_87),
        .wb_en_87(wb_en_87), .wb_addr_87(wb_addr_87), .wb_data_87(wb_data_87),
        .ex_wr_87(ex_wr_87), .ex_rd_87(ex_rd_87), .ex_ld_87(ex_ld_87),
        .mem_wr_87(mem_wr_87), .mem_rd_87(mem_rd_87),
        .br_pc_87(br_pc_87), .br_sel_87(br_sel_87), .id_valid_87(id_valid_87),
        .id_rs_87(id_rs_87), .id_rt_87(id_rt_87), .id_imm_87(id_imm_87),
        .id_dst_87(id_dst_87), .id_alu_87(id_alu_87), .id_ctl_87(id_ctl_87),
        .id_npc_87(id_npc_87), .id_illegal_87(id_illegal_87)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef enum {
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT,
        M_SLL, M_SRL, M_JR, M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI,
        M_SLTI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_BAD
    } mn_t;

    function automatic mn_t classify(input logic [31:0] w);
        if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h20: return M_ADD;   6'h21: return M_ADDU;
                6'h22: return M_SUB;   6'h23: return M_SUBU;
                6'h24: return M_AND;   6'h25: return M_OR;
                6'h26: return M_XOR;   6'h27: return M_NOR;
                6'h2A: return M_SLT;   6'h00: return M_SLL;
                6'h02: return M_SRL;   6'h08: return M_JR;
                default: return M_BAD;
            endcase
        end
        case (w[31:26])
            6'h08: return M_ADDI;  6'h09: return M_ADDIU;
            6'h0C: return M_ANDI;  6'h0D: return M_ORI;
            6'h0E: return M_XORI;  6'h0A: return M_SLTI;
            6'h0F: return M_LUI;   6'h23: return M_LW;
            6'h2B: return M_SW;    6'h04: return M_BEQ;
            6'h05: return M_BNE;   6'h02: return M_J;
            default: return M_BAD;
        endcase
    endfunction

    function automatic bit reads_rs(input mn_t m);
        return m inside {M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR,
                         M_SLT, M_JR, M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI,
                         M_SLTI, M_LW, M_SW, M_BEQ, M_BNE};
    endfunction

    function automatic bit reads_rt(input mn_t m);
        return m inside {M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR,
                         M_SLT, M_SLL, M_SRL, M_SW, M_BEQ, M_BNE};
    endfunction

    function automatic bit uses(input mn_t m, input logic [31:0] w, input logic [4:0] r);
        if (r == 0) return 1'b0;
        return (reads_rs(m) && w[25:21] == r) || (reads_rt(m) && w[20:16] == r);
    endfunction

    function automatic logic [3:0] alu_of(input mn_t m);
        case (m)
            M_SUB, M_SUBU, M_BEQ, M_BNE: return 4'd1;
            M_AND, M_ANDI: return 4'd2;
            M_OR, M_ORI:   return 4'd3;
            M_XOR, M_XORI: return 4'd4;
            M_NOR:         return 4'd5;
            M_SLT, M_SLTI: return 4'd6;
            M_SLL:         return 4'd7;
            M_SRL:         return 4'd8;
            M_LUI:         return 4'd9;
            default:       return 4'd0;
        endcase
    endfunction

    function automatic logic [4:0] ctl_of(input mn_t m, input logic [31:0] w);
        bit wr;
        wr = !(m inside {M_JR, M_SW, M_BEQ, M_BNE, M_J}) && w != 0;
        return {wr, m == M_LW, m == M_SW, m == M_LW,
                m inside {M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI,
                          M_SLTI, M_LUI, M_LW, M_SW}};
    endfunction

    function automatic logic [31:0] imm_of(input mn_t m, input logic [31:0] w);
        if (m == M_LUI) return {16'h0, w[15:0]} << 16;
        if (m inside {M_ANDI, M_ORI, M_XORI}) return {16'h0, w[15:0]};
        return 32'($signed(w[15:0]));
    endfunction

    logic [31:0] m_rf [32];
    bit          m_wait;
    logic [31:0] m_exp;
    bit          m_ill;
    bit          e_sel;
    logic [31:0] e_pc;
    bit          e_valid;
    logic [31:0] e_rs, e_rt, e_imm, e_npc;
    logic [4:0]  e_dst, e_ctl;
    logic [3:0]  e_alu;
    logic        obs_sel;
    logic [31:0] obs_pc;

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        if (r == 0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en_87 && wb_addr_87 == r) return wb_data_87;
`endif
        return m_rf[r];
    endfunction

    task automatic model_cycle();
        mn_t m;
        logic [31:0] a, b, tgt;
        bit acc, hz, tk;
        e_sel = 0;
        e_pc = 0;
        e_valid = 0;
        e_ctl = 0;
        if (rst_87) begin
            m_wait = 0;
            m_exp = 0;
            m_ill = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            return;
        end
        m = classify(instr_87);
        a = rd_reg(instr_87[25:21]);
        b = rd_reg(instr_87[20:16]);
        acc = !m_wait || npc_87 == m_exp;
        hz = 0;
        if (m != M_BAD) begin
            if (ex_ld_87 && uses(m, instr_87, ex_rd_87)) hz = 1;
            if (m inside {M_BEQ, M_BNE, M_JR} &&
                ((ex_wr_87 && uses(m, instr_87, ex_rd_87)) ||
                 (mem_wr_87 && uses(m, instr_87, mem_rd_87)))) hz = 1;
`ifndef DECODE_WB_BYPASS_EN
            if (wb_en_87 && uses(m, instr_87, wb_addr_87)) hz = 1;
`endif
        end
        tk = m == M_J || m == M_JR || (m == M_BEQ && a == b) || (m == M_BNE && a != b);
        if (m == M_JR) tgt = a;
        else if (m == M_J) tgt = {npc_87[31:28], instr_87[25:0], 2'b00};
        else tgt = npc_87 + 32'($signed(instr_87[15:0])) * 4;
        if (!acc) begin
        end else if (m == M_BAD) begin
            m_ill = 1;
            m_wait = 0;
        end else if (hz) begin
            e_sel = 1;
            e_pc = npc_87 - 4;
            m_wait = 1;
            m_exp = npc_87;
        end else begin
            m_wait = tk;
            if (tk) begin
                e_sel = 1;
                e_pc = tgt;
                m_exp = tgt + 4;
            end
            e_valid = 1;
            e_rs = a;
            e_rt = b;
            e_imm = imm_of(m, instr_87);
            e_dst = (m inside {M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR,
                               M_NOR, M_SLT, M_SLL, M_SRL, M_JR})
                    ? instr_87[15:11] : instr_87[20:16];
            e_alu = alu_of(m);
            e_ctl = ctl_of(m, instr_87);
            e_npc = npc_87;
        end
        if (wb_en_87 && wb_addr_87 != 0) m_rf[wb_addr_87] = wb_data_87;
    endtask

    task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc4,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic xw, input logic [4:0] xr, input logic xl,
                        input logic mw, input logic [4:0] mr);
        rst_87 = r;
        instr_87 = ins;
        npc_87 = pc4;
        wb_en_87 = we;
        wb_addr_87 = wa;
        wb_data_87 = wd;
        ex_wr_87 = xw;
        ex_rd_87 = xr;
        ex_ld_87 = xl;
        mem_wr_87 = mw;
        mem_rd_87 = mr;
        #1;
        model_cycle();
        obs_sel = br_sel_87;
        obs_pc = br_pc_87;
        chk("br_sel", obs_sel, e_sel);
        if (e_sel) chk("br_pc", obs_pc, e_pc);
        @(negedge clk_87);
        chk("id_valid", id_valid_87, e_valid);
        chk("id_ctl", id_ctl_87, e_ctl);
        chk("id_illegal", id_illegal_87, m_ill);
        if (e_valid) begin
            chk("id_rs", id_rs_87, e_rs);
            chk("id_rt", id_rt_87, e_rt);
            chk("id_imm", id_imm_87, e_imm);
            chk("id_dst", id_dst_87, e_dst);
            chk("id_alu", id_alu_87, e_alu);
            chk("id_npc", id_npc_87, e_npc);
        end
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] pc4);
        step(1'b0, ins, pc4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    logic [5:0] rfn [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                             6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08};
    logic [5:0] iop [12] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A,
                             6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    function automatic logic [31:0] rand_instr();
        logic [4:0] s, t, d;
        int k;
        s = 5'($urandom_range(0, 5));
        t = 5'($urandom_range(0, 5));
        d = 5'($urandom_range(0, 5));
        k = $urandom_range(0, 99);
        if (k < 4) return 32'h0;
        if (k < 7) return {6'h3F, s, t, 16'($urandom)};
        if (k < 9) return {6'h00, s, t, d, 5'h0, 6'h3F};
        if (k < 50) return {6'h00, s, t, d, 5'($urandom), rfn[$urandom_range(0, 11)]};
        return {iop[$urandom_range(0, 11)], s, t, 16'($urandom)};
    endfunction

    logic [31:0] pc;
    logic [31:0] wd;

    initial begin
        step(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 32'h20010005, 32'h4, 1'b1, 5'd3, 32'd9, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        chk("rst_valid", id_valid_87, 32'd0);
        chk("rst_illegal", id_illegal_87, 32'd0);
        chk("rst_rs", id_rs_87, 32'd0);

        run(32'h20010005, 32'h4);
        chk("addi_imm", id_imm_87, 32'd5);
        chk("addi_dst", id_dst_87, 32'd1);
        chk("addi_ctl", id_ctl_87, 32'b10001);
        chk("addi_valid", id_valid_87, 32'd1);

        step(1'b0, 32'h00401820, 32'h8, 1'b1, 5'd2, 32'hDEADBEEF,
             1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
`ifdef DECODE_WB_BYPASS_EN
        chk("byp_rs", id_rs_87, 32'hDEADBEEF);
        chk("byp_sel", obs_sel, 32'd0);
`else
        chk("wb_stall_sel", obs_sel, 32'd1);
        chk("wb_stall_pc", obs_pc, 32'h4);
        chk("wb_stall_bubble", id_valid_87, 32'd0);
        run(32'h00401820, 32'h8);
        chk("wb_refetch_rs", id_rs_87, 32'hDEADBEEF);
        chk("wb_refetch_valid", id_valid_87, 32'd1);
`endif

        step(1'b0, 32'h00842820, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0);
        chk("lu_sel", obs_sel, 32'd1);
        chk("lu_pc", obs_pc, 32'h1C);
        chk("lu_bubble", id_valid_87, 32'd0);
        run(32'h20050001, 32'h24);
        chk("lu_drop", id_valid_87, 32'd0);
        run(32'h00842820, 32'h20);
        chk("lu_decode", id_valid_87, 32'd1);
        chk("lu_dst", id_dst_87, 32'd5);

        step(1'b0, 32'h0, 32'h30, 1'b1, 5'd1, 32'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 32'h0, 32'h34, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        run(32'h10220003, 32'h40);
        chk("beq_sel", obs_sel, 32'd1);
        chk("beq_pc", obs_pc, 32'h4C);
        run(32'h20060001, 32'h44);
        chk("beq_drop44", id_valid_87, 32'd0);
        run(32'h20060002, 32'h48);
        chk("beq_drop48", id_valid_87, 32'd0);
        run(32'h20060003, 32'h50);
        chk("beq_target", id_valid_87, 32'd1);
        chk("beq_target_imm", id_imm_87, 32'd3);

        run(32'h08000040, 32'h10000004);
        chk("j_sel", obs_sel, 32'd1);
        chk("j_pc", obs_pc, 32'h10000100);
        run(32'h0, 32'h10000104);
        chk("j_landing", id_valid_87, 32'd1);

        run(32'hFC000000, 32'h10000108);
        chk("ill_bubble", id_valid_87, 32'd0);
        chk("ill_flag", id_illegal_87, 32'd1);
        step(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        chk("ill_cleared", id_illegal_87, 32'd0);

        pc = 32'h100;
        for (int c = 0; c < 1500; c++) begin
            if (m_wait && $urandom_range(0, 1) == 1) pc = m_exp - 4;
            else if ($urandom_range(0, 19) == 0) pc = $urandom & 32'hFFFF_FFFC;
            pc = pc + 4;
            wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2));
            step($urandom_range(0, 79) == 0, rand_instr(), pc,
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 5)), wd,
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 5)),
                 $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 5)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction decode stage of the five-stage MIPS pipeline: the consumer end of the fetch interface. Each cycle it accepts the fetched instruction word and its PC+4 from the fetch stage. It decodes the instruction, reads the 32×32 register file, and loads the ID/EX pipeline register. It resolves branches, jumps and hazards in ID, and drives the PC-select redirect back into the fetch stage.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.
- `DATA_W`, default 32: register and data width.
- Instruction and address widths are taken from `` `INSTR_WIDTH `` and `` `ADDR_WIDTH `` in `mips_defs.vh`.

Ports:
- `clk_87`  in  1  sole clock; all state updates on its rising edge.
- `rst_87`  in  1  synchronous, active-high reset.
- `instr_87`  in  INSTR_WIDTH  instruction word from fetch.
- `npc_87`  in  ADDR_WIDTH  PC+4 of `instr_87`.
- `wb_en_87`, `wb_addr_87`, `wb_data_87`  in  1 / REG_AW / DATA_W  register-file write port, from WB.
- `ex_wr_87`, `ex_rd_87`, `ex_ld_87`  in  1 / REG_AW / 1  EX-stage write-enable, destination and is-load.
- `mem_wr_87`, `mem_rd_87`  in  1 / REG_AW  MEM-stage write-enable and destination.
- `br_pc_87`  out  ADDR_WIDTH  redirect address to fetch; combinational.
- `br_sel_87`  out  1  redirect strobe to fetch; combinational, one cycle per redirect.
- `id_valid_87`  out  1  ID/EX holds a real instruction; 0 means bubble.
- `id_rs_87`, `id_rt_87`  out  DATA_W  operand values.
- `id_imm_87`  out  DATA_W  extended immediate.
- `id_dst_87`  out  REG_AW  destination register.
- `id_alu_87`  out  4  ALU control code.
- `id_ctl_87`  out  5  control bits, in order `{reg_write, mem_read, mem_write, mem_to_reg, alu_src}`.
- `id_npc_87`  out  ADDR_WIDTH  pipelined PC+4.
- `id_illegal_87`  out  1  unsupported opcode or funct seen; sticky until reset.

## Operation
- **Supported instructions:**
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sll, srl, jr.
  - I-type: addi, addiu, andi, ori, xori, slti, lui, lw, sw, beq, bne.
  - J-type: j.
  - The all-zero word is a NOP: it is loaded with `id_valid_87`=1 and `reg_write`=0.
  - Any other opcode or funct produces a bubble and sets `id_illegal_87`.
- **Immediate extension:**
  - andi, ori and xori zero-extend.
  - lui places imm16 in bits [31:16] with zeros below.
  - All other I-type instructions sign-extend.
- **Destination register:**
  - R-type uses rd. I-type uses rt.
  - sw, branches and jumps force `reg_write`=0.
- **Register file:**
  - `$0` reads as 0 and ignores writes.
  - All 32 registers clear on reset.
- **Control transfer targets:**
  - beq/bne target = npc + (sext(imm16)<<2).
  - j target = {npc[31:28], imm26, 2'b00}.
  - jr target = rs.
  - A taken branch, j or jr asserts `br_sel_87` with that target, then enters WAIT with expect = target+4.
  - No delay slot.
- **Hazard stall:** a stall applies in either of these cases:
  - `ex_ld_87` is set and `ex_rd_87` is nonzero and matches a used source register;
  - a branch or jr source register matches a nonzero `ex_rd_87` with `ex_wr_87` set, or a nonzero `mem_rd_87` with `mem_wr_87` set.
- **On a stall:**
  - `br_pc_87` = npc−4 and `br_sel_87`=1;
  - a bubble is loaded into ID/EX;
  - the block enters WAIT with expect = npc.
- **State machine, two states, RUN and WAIT:**
  - RUN → WAIT on a redirect.
  - In WAIT, every incoming instruction with npc ≠ expect is dropped: a bubble is loaded, with no redirect and no illegal flag.
  - WAIT → RUN on the cycle npc == expect. That instruction is decoded normally in the same cycle, including its hazard and branch checks.
- **Priority within one cycle:** stall > control transfer > normal decode.

## Timing
- ID/EX latency is one cycle: inputs sampled at edge N appear on the `id_*` outputs after edge N.
- `br_sel_87` and `br_pc_87` are combinational from the current inputs and state. They are 0 in WAIT, except on the matching cycle.
- The redirect is independent of fetch latency; WAIT absorbs any number of in-flight words.
- **Reset:**
  - all `id_*` outputs are 0, `id_valid_87`=0 and `id_illegal_87`=0;
  - state is RUN and expect is 0;
  - the register file is all-zero;
  - `br_sel_87`=0 while `rst_87` is high;
  - reset asserted mid-WAIT returns to RUN on the next edge.
- A WB write and a decode read of the same register in the same cycle are governed by the macro below.
- PC arithmetic wraps modulo 2^ADDR_WIDTH.

## Configuration
- `` `DECODE_WB_BYPASS_EN `` defined:
  - the register file is write-first: a same-cycle read of `wb_addr_87` returns `wb_data_87`;
  - no extra stall.
- Undefined:
  - a read returns the old value;
  - a same-cycle `wb_en_87` write to a nonzero register that is a used source is treated as a hazard stall, with the redirect and WAIT behaviour above.

## Test plan
- **Reset and simple decode:** after reset, feed `addi $1,$0,5` (0x20010005) with npc=4. Next cycle: `id_imm_87`=5, `id_dst_87`=1, `reg_write`=1, `alu_src`=1, `id_valid_87`=1.
- **WB bypass:** WB writes $2=0xDEADBEEF in the same cycle as decoding `add $3,$2,$0`. With the macro: `id_rs_87`=0xDEADBEEF. Without it: bubble, `br_pc_87`=npc−4, then the correct value once the refetch arrives.
- **Load-use:** `ex_ld_87`=1, `ex_rd_87`=4, decoding `add $5,$4,$4` at npc=0x20. Response: `br_sel_87`=1, `br_pc_87`=0x1C, bubble. Words with npc≠0x20 are dropped; the word with npc=0x20 decodes once the hazard has cleared.
- **Taken beq:** $1=$2, `beq $1,$2,+3` at npc=0x40. Response: `br_pc_87`=0x4C. The words with npc 0x44 and 0x48 become bubbles; the word with npc 0x50 decodes.
- **Jump:** `j 0x100` (imm26=0x40) at npc=0x10000004. Response: `br_pc_87`=0x10000100.
- **Illegal opcode and reset recovery:** feed opcode 0x3F. Response: bubble and `id_illegal_87`=1. Asserting `rst_87` for one cycle clears it.
